// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, line levels, FSM state encoding.
// Common to the tx block and the future rx block.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP, ST_BREAK
  } state_t;

  // Narrower payloads are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input int mode, input logic [8:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// restart realigns the count to the start of a new bit period.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (restart || cnt == LAST)  cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and internal baud timing.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 busy
);
  import uart_pkg::*;

  state_t                 state;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par;
  logic [4:0]             bit_cnt;
  logic                   bit_end, restart, take, frame_done;

  // Last bit period of the frame (stop or gap) finishes at this edge.
  assign frame_done = bit_end &&
    ((state == ST_STOP && bit_cnt == 5'(STOP_BITS - 1) && GAP_BITS == 0) ||
     (state == ST_GAP  && bit_cnt == 5'(GAP_BITS - 1)));

`ifdef UART_TX_BREAK_EN
  assign take    = din_valid && !brk && (din_ready || frame_done);
  assign restart = take || (state == ST_BREAK && bit_cnt == 5'd0 && !brk);
`else
  assign take    = din_valid && (din_ready || frame_done);
  assign restart = take;
`endif

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      tx        <= STOP_BIT;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else if (take) begin
      state     <= ST_START;
      shreg     <= din;
      par       <= calc_parity(PARITY, 9'(din));
      bit_cnt   <= '0;
      tx        <= START_BIT;
      din_ready <= 1'b0;
      busy      <= 1'b1;
    end
`ifdef UART_TX_BREAK_EN
    else if (brk && (state == ST_IDLE || frame_done)) begin
      state     <= ST_BREAK;
      bit_cnt   <= '0;
      tx        <= 1'b0;
      din_ready <= 1'b0;
      busy      <= 1'b1;
    end else if (state == ST_BREAK) begin
      // bit_cnt 0: line held low; 1: mark-after-break period.
      if (bit_cnt == 5'd0) begin
        if (!brk) begin
          tx      <= 1'b1;
          bit_cnt <= 5'd1;
        end
      end else if (bit_end) begin
        state     <= ST_IDLE;
        din_ready <= 1'b1;
        busy      <= 1'b0;
      end
    end
`endif
    else if (frame_done) begin
      state     <= ST_IDLE;
      tx        <= STOP_BIT;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else if (bit_end) begin
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        ST_DATA: begin
          if (bit_cnt == 5'(DATA_BITS - 1)) begin
            bit_cnt <= '0;
            if (PARITY != PAR_NONE) begin
              state <= ST_PARITY;
              tx    <= par;
            end else begin
              state <= ST_STOP;
              tx    <= STOP_BIT;
            end
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          state   <= ST_STOP;
          tx      <= STOP_BIT;
          bit_cnt <= '0;
        end
        ST_STOP: begin
          if (bit_cnt == 5'(STOP_BITS - 1)) begin
            state   <= ST_GAP;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP:  bit_cnt <= bit_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
